// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder.
// Contents: FSM state encoding, the NOP returned on faulted fetches, and
// the default wait-state count.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // RISC-V canonical NOP (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int DEFAULT_LATENCY = 2;

endpackage

// File: rtl/imem_array.sv
// Word-organised single-port SRAM with four byte-lane write enables.
// Ports: clk; en/we select a read or masked write at the rising edge;
//        mask[3:0] lane enables, idx word index, wdata in, rdata registered out.
// The read register only updates on a read access; contents are never reset.
module imem_array #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic                 we,
  input  logic [3:0]           mask,
  input  logic [AddrWidth-1:0] idx,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  localparam int LaneW = DataWidth / 4;

  logic [DataWidth-1:0] mem [2**AddrWidth];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (mask[i]) begin
            mem[idx][i*LaneW +: LaneW] <= wdata[i*LaneW +: LaneW];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-side responder for the fetch port: accepts one request at a time,
// services it from imem_array after Latency cycles and pulses valid once.
// Ports: clk, rst (async, active-high); request/we_re/mask/address/wdata in;
//        rdata/valid/busy/err out, all driven from registers only.
// Optional macro IMEM_ERR_EN: flags misaligned or out-of-range addresses,
//        returning NOP on reads and discarding writes.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 10,
  parameter int Latency   = DEFAULT_LATENCY
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 request,
  input  logic                 we_re,
  input  logic [3:0]           mask,
  input  logic [DataWidth-1:0] address,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata,
  output logic                 valid,
  output logic                 busy,
  output logic                 err
);

  localparam logic [3:0] LatM1 = 4'(Latency - 1);

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic accept, enter_resp;

  // Holding registers for the transaction in flight
  logic                 held_we;
  logic [3:0]           held_mask;
  logic [AddrWidth-1:0] held_idx;
  logic [DataWidth-1:0] held_wdata;
  logic                 held_err;

  logic                 req_err;
  logic                 op_we;
  logic [3:0]           op_mask;
  logic [AddrWidth-1:0] op_idx;
  logic [DataWidth-1:0] op_wdata;
  logic                 op_err;
  logic [DataWidth-1:0] ram_q;

`ifdef IMEM_ERR_EN
  assign req_err = (address[1:0] != 2'b00) || ((address >> (AddrWidth + 2)) != '0);
`else
  // Word index truncates the byte offset and wraps on the upper bits
  logic addr_unused;
  assign addr_unused = ^{address[1:0], address >> (AddrWidth + 2)};
  assign req_err     = 1'b0;
`endif

  assign accept = request && (state_q == IDLE || state_q == RESP);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          cnt_d = LatM1;
          if (Latency == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_we    <= 1'b0;
      held_mask  <= '0;
      held_idx   <= '0;
      held_wdata <= '0;
      held_err   <= 1'b0;
    end else if (accept) begin
      held_we    <= we_re;
      held_mask  <= mask;
      held_idx   <= address[AddrWidth+1:2];
      held_wdata <= wdata;
      held_err   <= req_err;
    end
  end

  // With a single wait-state the array access happens on the accept edge
  // itself, so it must see the live request rather than the holding regs.
  generate
    if (Latency == 1) begin : g_direct
      assign op_we    = we_re;
      assign op_mask  = mask;
      assign op_idx   = address[AddrWidth+1:2];
      assign op_wdata = wdata;
      assign op_err   = req_err;
    end else begin : g_held
      assign op_we    = held_we;
      assign op_mask  = held_mask;
      assign op_idx   = held_idx;
      assign op_wdata = held_wdata;
      assign op_err   = held_err;
    end
  endgenerate

  // Faulted requests never touch the array: writes are dropped, reads
  // are answered with NOP below.
  imem_array #(
    .DataWidth(DataWidth),
    .AddrWidth(AddrWidth)
  ) u_array (
    .clk  (clk),
    .en   (enter_resp && !op_err),
    .we   (op_we),
    .mask (op_mask),
    .idx  (op_idx),
    .wdata(op_wdata),
    .rdata(ram_q)
  );

  // Holding regs always describe the transaction being answered in RESP,
  // so the outputs decode purely from registered state.
  assign valid = (state_q == RESP);
  assign busy  = (state_q == WAIT);
  assign err   = valid && held_err;
  assign rdata = (valid && !held_we) ? (held_err ? DataWidth'(NOP_INSTR) : ram_q) : '0;

endmodule
